// File: rtl/sdm_seq_pkg.sv
// sdm_seq_pkg
//   Shared types and default constants for the sigma-delta sample sequencer.
//   - state_t  : sequencer FSM state (IDLE, RUN, STOP)
//   - sample_t : signed sample at the default width
//   - DEFAULT_DATA_W / DEFAULT_OSR / DEFAULT_FIFO_DEPTH : default parameters
package sdm_seq_pkg;

  localparam int DEFAULT_DATA_W     = 16;
  localparam int DEFAULT_OSR        = 64;
  localparam int DEFAULT_FIFO_DEPTH = 16;

  typedef logic signed [DEFAULT_DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/sdm_sample_fifo.sv
// sdm_sample_fifo
//   Synchronous first-word fall-through FIFO holding host samples.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     push     : write din (ignored when full or when flush is high)
//     pop      : drop the head entry (ignored when empty)
//     flush    : empty the FIFO on this edge
//     din      : write data
//     dout     : head entry, shown combinationally from the storage registers
//     level    : number of stored entries, 0..DEPTH
//     full     : level == DEPTH
//     empty    : level == 0
module sdm_sample_fifo
  import sdm_seq_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; only entries below level are ever observed.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sdm_sample_sequencer.sv
// sdm_sample_sequencer
//   Releases buffered host samples to a sigma-delta modulator input once
//   every OSR clocks, with start/stop control, muting when idle and a
//   sticky underflow flag.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     enable        : 1 = run the stream, 0 = stop at the next sample boundary
//     flush         : pulse, empties the sample FIFO
//     s_data/s_valid/s_ready : host sample stream (valid/ready handshake)
//     mod_din       : sample presented to the modulator
//     sample_tick   : pulse in the cycle mod_din takes a new value
//     fifo_level    : number of buffered samples
//     busy          : sequencer not idle
//     underflow     : sticky, set when a sample boundary finds the FIFO empty
//     clr_underflow : clears underflow (a simultaneous set wins)
module sdm_sample_sequencer
  import sdm_seq_pkg::*;
#(
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int OSR            = DEFAULT_OSR,
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int UNDERFLOW_HOLD = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          flush,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_W-1:0]             mod_din,
  output logic                          sample_tick,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          underflow,
  input  logic                          clr_underflow
);

  localparam int PW = $clog2(OSR);
  localparam logic [PW-1:0] LAST_PHASE = PW'(OSR - 1);

  state_t            state;
  logic [PW-1:0]     phase;
  logic              tick;
  logic              run_tick;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_dout;

  assign tick     = (state != IDLE) && (phase == LAST_PHASE);
  // A STOP boundary with enable raised again behaves as a normal RUN boundary.
  assign run_tick = tick && ((state == RUN) || enable);
  assign fifo_pop = run_tick && !fifo_empty;
  assign s_ready  = !fifo_full;
  assign busy     = (state != IDLE);

  sdm_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid && s_ready),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (s_data),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= '0;
      mod_din     <= '0;
      sample_tick <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      sample_tick <= tick;
      if (clr_underflow) underflow <= 1'b0;

      case (state)
        IDLE: begin
          phase   <= '0;
          mod_din <= '0;
          if (enable) state <= RUN;
        end
        RUN, STOP: begin
          phase <= tick ? '0 : phase + PW'(1);
          if ((state == RUN) || enable) begin
            state <= enable ? RUN : STOP;
            if (tick) begin
              if (!fifo_empty) begin
                mod_din <= fifo_dout;
              end else begin
                // Placed after the clear above so a simultaneous set wins.
                underflow <= 1'b1;
                if (UNDERFLOW_HOLD == 0) mod_din <= '0;
              end
            end
          end else if (tick) begin
            mod_din <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          phase <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdm_sample_sequencer.sv
// tb_sdm_sample_sequencer
//   Directed scenarios plus randomized traffic on two sequencer instances
//   (underflow hold on and off), checked every cycle against a queue-based
//   behavioural model, with literal expectations at key points.
module tb_sdm_sample_sequencer;
  import sdm_seq_pkg::*;

  localparam int OSR   = DEFAULT_OSR;
  localparam int DEPTH = DEFAULT_FIFO_DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic        clr_underflow = 1'b0;
  sample_t     s_data = '0;

  logic        s_ready, sample_tick, busy, underflow;
  logic [15:0] mod_din;
  logic [4:0]  fifo_level;
  logic        s_ready_h0, sample_tick_h0, busy_h0, underflow_h0;
  logic [15:0] mod_din_h0;
  logic [4:0]  fifo_level_h0;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  sdm_sample_sequencer #(.UNDERFLOW_HOLD(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mod_din(mod_din), .sample_tick(sample_tick), .fifo_level(fifo_level),
    .busy(busy), .underflow(underflow), .clr_underflow(clr_underflow)
  );

  sdm_sample_sequencer #(.UNDERFLOW_HOLD(0)) dut_h0 (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_h0),
    .mod_din(mod_din_h0), .sample_tick(sample_tick_h0), .fifo_level(fifo_level_h0),
    .busy(busy_h0), .underflow(underflow_h0), .clr_underflow(clr_underflow)
  );

  // Behavioural model: a queue of samples, a mode (0 idle, 1 run, 2 stop),
  // the position within the current sample period, and the output values.
  logic [15:0] q[$];
  int          m_mode  = 0;
  int          m_phase = 0;
  logic [15:0] m_din   = '0;
  logic [15:0] m_din0  = '0;
  logic        m_tick  = 1'b0;
  logic        m_uf    = 1'b0;

  always @(posedge clk) begin : model
    int pre;
    bit boundary, take_sample;
    if (rst) begin
      q.delete();
      m_mode = 0; m_phase = 0; m_din = '0; m_din0 = '0; m_tick = 1'b0; m_uf = 1'b0;
    end else begin
      pre         = q.size();
      boundary    = (m_mode != 0) && (m_phase == OSR - 1);
      take_sample = boundary && (m_mode == 1 || enable);
      m_tick      = boundary;
      if (clr_underflow) m_uf = 1'b0;
      if (take_sample) begin
        if (pre > 0) begin
          m_din  = q.pop_front();
          m_din0 = m_din;
        end else begin
          m_uf   = 1'b1;
          m_din0 = '0;
        end
      end
      if (s_valid && pre < DEPTH && !flush) q.push_back(s_data);
      if (flush) q.delete();
      if (m_mode == 0) begin
        m_phase = 0;
        if (enable) m_mode = 1;
      end else begin
        m_phase = boundary ? 0 : m_phase + 1;
        if (enable) m_mode = 1;
        else if (m_mode == 1) m_mode = 2;
        else if (boundary) begin
          m_mode = 0; m_din = '0; m_din0 = '0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic en,
                               input logic fl, input logic clr, input logic r);
    s_valid = v; s_data = d; enable = en; flush = fl; clr_underflow = clr; rst = r;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    waitEdges(2);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("mod_din",     32'(mod_din),     32'(m_din));
      checkOutput("mod_din_h0",  32'(mod_din_h0),  32'(m_din0));
      checkOutput("sample_tick", 32'(sample_tick), 32'(m_tick));
      checkOutput("fifo_level",  32'(fifo_level),  32'(q.size()));
      checkOutput("s_ready",     32'(s_ready),     32'(q.size() != DEPTH));
      checkOutput("busy",        32'(busy),        32'(m_mode != 0));
      checkOutput("underflow",   32'(underflow),   32'(m_uf));
    end
  end

  initial begin
    int rate;
    $display("[TB] start");
    waitEdges(1);
    check_en = 1'b1;

    // Reset state.
    doReset();
    @(negedge clk);
    checkOutput("rst_mod_din", 32'(mod_din), 32'h0);
    checkOutput("rst_level",   32'(fifo_level), 32'h0);
    checkOutput("rst_s_ready", 32'(s_ready), 32'h1);
    checkOutput("rst_busy",    32'(busy), 32'h0);

    // Three queued samples released one per period.
    applyStimulus(1'b1, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0); waitEdges(1);
    applyStimulus(1'b1, 16'h2000, 1'b0, 1'b0, 1'b0, 1'b0); waitEdges(1);
    applyStimulus(1'b1, 16'hC000, 1'b0, 1'b0, 1'b0, 1'b0); waitEdges(1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    waitEdges(64);
    @(negedge clk);
    checkOutput("t1_pre_tick", 32'(sample_tick), 32'h0);
    checkOutput("t1_pre_din",  32'(mod_din), 32'h0);
    checkOutput("t1_model_lvl", 32'(q.size()), 32'd3);
    waitEdges(1); @(negedge clk);
    checkOutput("t1_din0", 32'(mod_din), 32'h4000);
    checkOutput("t1_tick0", 32'(sample_tick), 32'h1);
    checkOutput("t1_lvl0", 32'(fifo_level), 32'd2);
    waitEdges(64); @(negedge clk);
    checkOutput("t1_din1", 32'(mod_din), 32'h2000);
    checkOutput("t1_lvl1", 32'(fifo_level), 32'd1);
    waitEdges(64); @(negedge clk);
    checkOutput("t1_din2", 32'(mod_din), 32'hC000);
    checkOutput("t1_model_din2", 32'(m_din), 32'hC000);
    checkOutput("t1_lvl2", 32'(fifo_level), 32'd0);

    // Fill to full, then one pop frees a slot.
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 16'(16'h0111 * (i + 1)), 1'b0, 1'b0, 1'b0, 1'b0);
      waitEdges(1);
    end
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t2_full_ready", 32'(s_ready), 32'h0);
    checkOutput("t2_full_lvl", 32'(fifo_level), 32'd16);
    waitEdges(1); @(negedge clk);
    checkOutput("t2_17th_lvl", 32'(fifo_level), 32'd16);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    waitEdges(64); @(negedge clk);
    checkOutput("t2_before_pop", 32'(s_ready), 32'h0);
    waitEdges(1); @(negedge clk);
    checkOutput("t2_after_pop_ready", 32'(s_ready), 32'h1);
    checkOutput("t2_after_pop_lvl", 32'(fifo_level), 32'd15);
    checkOutput("t2_first_sample", 32'(mod_din), 32'h0111);
    enable = 1'b0;

    // Underflow with hold on / off; set beats a same-cycle clear.
    doReset();
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0); waitEdges(1);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    waitEdges(65); @(negedge clk);
    checkOutput("t3_first", 32'(mod_din), 32'h1234);
    checkOutput("t3_no_uf", 32'(underflow), 32'h0);
    waitEdges(63);
    clr_underflow = 1'b1;
    waitEdges(1);
    clr_underflow = 1'b0;
    @(negedge clk);
    checkOutput("t3_uf_set", 32'(underflow), 32'h1);
    checkOutput("t3_hold", 32'(mod_din), 32'h1234);
    checkOutput("t3_zero", 32'(mod_din_h0), 32'h0);
    clr_underflow = 1'b1;
    waitEdges(1);
    clr_underflow = 1'b0;
    @(negedge clk);
    checkOutput("t3_uf_clr", 32'(underflow), 32'h0);

    // Stop mid-period keeps the FIFO contents.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'(16'h0101 * (i + 1)), 1'b0, 1'b0, 1'b0, 1'b0);
      waitEdges(1);
    end
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    waitEdges(65); @(negedge clk);
    checkOutput("t4_lvl", 32'(fifo_level), 32'd2);
    waitEdges(10);
    enable = 1'b0;
    waitEdges(53); @(negedge clk);
    checkOutput("t4_stop_busy", 32'(busy), 32'h1);
    checkOutput("t4_stop_din", 32'(mod_din), 32'h0101);
    waitEdges(1); @(negedge clk);
    checkOutput("t4_mute", 32'(mod_din), 32'h0);
    checkOutput("t4_tick", 32'(sample_tick), 32'h1);
    checkOutput("t4_idle", 32'(busy), 32'h0);
    checkOutput("t4_kept", 32'(fifo_level), 32'd2);

    // Reset mid-run, then flush together with a push.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'(16'h0A00 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      waitEdges(1);
    end
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    waitEdges(31);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t5_pre_lvl", 32'(fifo_level), 32'd5);
    checkOutput("t5_pre_busy", 32'(busy), 32'h1);
    waitEdges(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_rst_busy", 32'(busy), 32'h0);
    checkOutput("t5_rst_lvl", 32'(fifo_level), 32'd0);
    checkOutput("t5_rst_din", 32'(mod_din), 32'h0);
    checkOutput("t5_rst_uf", 32'(underflow), 32'h0);
    applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0); waitEdges(1);
    applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0); waitEdges(1);
    applyStimulus(1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b0); waitEdges(1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t5_flush_lvl", 32'(fifo_level), 32'd0);
    waitEdges(1); @(negedge clk);
    checkOutput("t5_flush_drop", 32'(fifo_level), 32'd0);

    // Randomized traffic with varying host rate.
    doReset();
    enable = 1'b1;
    rate = 3;
    for (int c = 0; c < 6000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(0, 2))
          0:       rate = 1;
          1:       rate = 3;
          default: rate = 30;
        endcase
      end
      s_valid       = ($urandom_range(0, 99) < rate);
      s_data        = 16'($urandom);
      flush         = ($urandom_range(0, 199) == 0);
      clr_underflow = ($urandom_range(0, 39) == 0);
      rst           = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      waitEdges(1);
    end

    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitEdges(2);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdm_sample_sequencer.md
Name: sdm_sample_sequencer

Overview:
- Feeds the sigma-delta modulator's signed 16-bit `din` at a fixed oversampling rate.
- Buffers host samples in a small FIFO and releases one sample every OSR clocks.
- Manages start/stop and mutes the modulator input to zero when idle.
- Flags underflow when the host cannot keep pace.

Parameters:
- DATA_W, 16: sample width, signed two's complement.
- OSR, 64: clocks per sample update; must be >= 2.
- FIFO_DEPTH, 16: sample buffer depth; must be a power of two and >= 2.
- UNDERFLOW_HOLD, 1: on underflow, 1 = repeat last sample, 0 = output zero.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- enable  in  1  level; 1 = run the sample stream, 0 = stop at the next sample boundary.
- flush  in  1  single-cycle pulse; empties the FIFO.
- s_data  in  DATA_W  host sample, signed.
- s_valid  in  1  host sample valid.
- s_ready  out  1  FIFO can accept a sample.
- mod_din  out  DATA_W  sample driven to the modulator `din`, signed.
- sample_tick  out  1  one-cycle pulse in the cycle mod_din takes a new value.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of stored samples.
- busy  out  1  state != IDLE.
- underflow  out  1  sticky underflow flag.
- clr_underflow  in  1  clears underflow.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, phase=0, FIFO empty, mod_din=0, sample_tick=0, underflow=0, fifo_level=0, s_ready=1 on the following cycle; busy=0. Reset mid-operation discards all state.
- FIFO push: on s_valid && s_ready. s_ready = (fifo_level != FIFO_DEPTH), derived from registered level. No push when full; s_data is not captured and the host must hold it.
- Pop: only at a tick in RUN or STOP, when the FIFO is non-empty (registered level at that edge).
- Push and pop in the same cycle: both occur and level is unchanged.
- Push into an empty FIFO in a tick cycle: the pop sees empty, so underflow is raised; the pushed sample is kept for the next tick.
- flush: the FIFO becomes empty next cycle; a push in the same cycle is dropped. state, phase and mod_din are unaffected.
- Phase counter: 0..OSR-1. It counts only in RUN/STOP, is held at 0 in IDLE, and wraps.
- Tick: phase == OSR-1. At the tick edge mod_din loads the new value; sample_tick=1 in the following cycle, aligned with the new mod_din.
- IDLE: mod_din=0. enable=1 -> RUN next cycle with phase=0. With entry cycle T, the first mod_din update is visible at T+OSR.
- RUN: at a tick with the FIFO non-empty, pop into mod_din. At a tick with the FIFO empty, set underflow; mod_din = previous value if UNDERFLOW_HOLD, else 0. enable=0 -> STOP.
- STOP: phase keeps counting. At the next tick, mod_din <= 0, sample_tick pulses, state -> IDLE, phase -> 0. No pop; FIFO contents are retained. enable=1 while in STOP returns to RUN with no phase reset.
- underflow: set and clr_underflow in the same cycle -> set wins.
- Arithmetic: samples pass through unmodified; no saturation or scaling. fifo_level counts 0..FIFO_DEPTH inclusive.

Decomposition:
- Package sdm_seq_pkg holds:
  - state enum {IDLE, RUN, STOP}, 2 bits;
  - the default DATA_W, OSR and FIFO_DEPTH constants;
  - the signed sample typedef.
- Sub-module sdm_sample_fifo is a synchronous FIFO with the ports push, pop, flush, din, dout, level, full and empty.
  - dout shows the head entry combinationally from registers (first-word fall-through).
- The sequencer holds the FSM, phase counter, mod_din register and underflow flag.

Test Plan:
1. Reset, then push 0x4000, 0x2000, 0xC000, then enable=1 (OSR=64) -> mod_din=0x4000, 0x2000, 0xC000 with sample_tick at T+64, T+128 and T+192; fifo_level decrements 3 -> 0.
2. Push 16 samples with enable=0 -> s_ready=0 at level 16; a 17th s_valid is not accepted; one tick with enable=1 pops one and s_ready returns to 1 the cycle after the pop.
3. Enable with only 0x1234 queued -> second tick raises underflow; mod_din stays 0x1234 (UNDERFLOW_HOLD=1), or 0 in a build with UNDERFLOW_HOLD=0; clr_underflow asserted in the same cycle as an underflow leaves the flag set.
4. Drop enable mid-period at phase=10 with samples queued -> mod_din=0 at the next tick, busy=0 one cycle later, and queued samples are retained (fifo_level unchanged).
5. Assert rst at phase=30 in RUN with level=5 -> next cycle state=IDLE, mod_din=0, fifo_level=0, underflow=0; flush asserted together with s_valid empties the FIFO and drops the pushed sample.
